sqrt_share_ctrl: RTL and testbench

- Scheduler that shares one iterative square-root engine between NUM_REQ mean-square producers (e.g. voltage-RMS and current-RMS channels).
- Accepts mean-square operands over per-requester valid/ready handshakes and arbitrates round-robin.
- Sequences start/done with the engine and routes each result back to the requester that issued it.
- Supervises the engine with a timeout; sits between the RMS front-ends and the single square_root instance.

---
 rtl/sqrt_share_pkg.sv | 19 +
 rtl/sqrt_share_ctrl_if.sv | 36 +++
 rtl/rr_arbiter.sv | 30 +++
 rtl/sqrt_share_ctrl.sv | 140 ++++++++++++++
 tb/tb_sqrt_share_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sqrt_share_pkg.sv
// Shared types and helpers for the square-root engine scheduler.
package sqrt_share_pkg;

  localparam int TIMEOUT_CYC_DEF = 256;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // Operand width of a mean-square value: squared sample plus averaging headroom.
  function automatic int in_width(input int data_w, input int buf_bit_w);
    return 2 * data_w + buf_bit_w;
  endfunction

endpackage

// File: rtl/sqrt_share_ctrl_if.sv
// Requester-side and engine-side signal bundle of the square-root scheduler.
interface sqrt_share_ctrl_if
  import sqrt_share_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int DATA_W    = 16,
  parameter int BUF_BIT_W = 8
) ();

  localparam int IN_W = in_width(DATA_W, BUF_BIT_W);

  logic [NUM_REQ-1:0]           req_valid_i;
  logic [NUM_REQ-1:0][IN_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]           req_ready_o;
  logic [DATA_W-1:0]            res_data_o;
  logic [NUM_REQ-1:0]           res_valid_o;
  logic                         res_err_o;
  logic [IN_W-1:0]              sqrt_din_o;
  logic                         sqrt_start_o;
  logic                         sqrt_clr_o;
  logic [DATA_W-1:0]            sqrt_dout_i;
  logic                         sqrt_done_i;

  modport slave (
    input  req_valid_i, req_data_i, sqrt_dout_i, sqrt_done_i,
    output req_ready_o, res_data_o, res_valid_o, res_err_o,
           sqrt_din_o, sqrt_start_o, sqrt_clr_o
  );

  modport master (
    output req_valid_i, req_data_i, sqrt_dout_i, sqrt_done_i,
    input  req_ready_o, res_data_o, res_valid_o, res_err_o,
           sqrt_din_o, sqrt_start_o, sqrt_clr_o
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first active request at or after the pointer.
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [IDX_W-1:0] cand_s;
  logic [IDX_W-1:0] idx_s;
  logic             found_s;

  // Scan requesters in pointer order; the first hit wins.
  always_comb begin
    cand_s  = '0;
    idx_s   = '0;
    found_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s  = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
      idx_s   = (!found_s && req_i[cand_s]) ? cand_s : idx_s;
      found_s = found_s | req_i[cand_s];
    end
    idx_o   = idx_s;
    grant_o = found_s ? (NUM_REQ'(1'b1) << idx_s) : '0;
  end

endmodule

// File: rtl/sqrt_share_ctrl.sv
// Shares one iterative square-root engine among NUM_REQ producers with
// round-robin arbitration, result routing and a done-timeout supervisor.
module sqrt_share_ctrl
  import sqrt_share_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int DATA_W      = 16,
  parameter int BUF_BIT_W   = 8,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  sqrt_share_ctrl_if.slave   bus,
  output logic               busy_o
);

  localparam int IN_W  = in_width(DATA_W, BUF_BIT_W);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  state_e             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   idx_q;
  logic [NUM_REQ-1:0] ready_q;
  logic [NUM_REQ-1:0] res_valid_q;
  logic [DATA_W-1:0]  res_data_q;
  logic               err_q;
  logic [IN_W-1:0]    din_q;
  logic               start_q;
  logic               clr_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [NUM_REQ-1:0] arb_grant_d;
  logic [IDX_W-1:0]   arb_idx_d;
  logic [IDX_W-1:0]   ptr_d;
  logic [NUM_REQ-1:0] idx_onehot_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i   (bus.req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant_d),
    .idx_o   (arb_idx_d)
  );

  assign ptr_d        = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1'b1);
  assign idx_onehot_d = NUM_REQ'(1'b1) << idx_q;

  // Scheduler FSM; every output is registered on the transition into its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      idx_q       <= '0;
      ready_q     <= '0;
      res_valid_q <= '0;
      res_data_q  <= '0;
      err_q       <= 1'b0;
      din_q       <= '0;
      start_q     <= 1'b0;
      clr_q       <= 1'b0;
      cnt_q       <= '0;
    end else if (clr_i) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      idx_q       <= '0;
      ready_q     <= '0;
      res_valid_q <= '0;
      res_data_q  <= '0;
      err_q       <= 1'b0;
      din_q       <= '0;
      start_q     <= 1'b0;
      clr_q       <= 1'b1;
      cnt_q       <= '0;
    end else begin
      ready_q     <= '0;
      res_valid_q <= '0;
      err_q       <= 1'b0;
      start_q     <= 1'b0;
      clr_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|bus.req_valid_i) begin
            idx_q   <= arb_idx_d;
            ready_q <= arb_grant_d;
            state_q <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // A producer that withdrew keeps its turn: no pointer update here.
          if (bus.req_valid_i[idx_q]) begin
            din_q   <= bus.req_data_i[idx_q];
            start_q <= 1'b1;
            state_q <= ST_ISSUE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.sqrt_done_i) begin
            res_data_q  <= bus.sqrt_dout_i;
            res_valid_q <= idx_onehot_d;
            din_q       <= '0;
            state_q     <= ST_RESP;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 2)) begin
            res_data_q  <= '0;
            err_q       <= 1'b1;
            clr_q       <= 1'b1;
            res_valid_q <= idx_onehot_d;
            din_q       <= '0;
            state_q     <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1'b1);
          end
        end
        ST_RESP: begin
          ptr_q   <= ptr_d;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready_o  = ready_q;
  assign bus.res_valid_o  = res_valid_q;
  assign bus.res_data_o   = res_data_q;
  assign bus.res_err_o    = err_q;
  assign bus.sqrt_din_o   = din_q;
  assign bus.sqrt_start_o = start_q;
  assign bus.sqrt_clr_o   = clr_q;
  assign busy_o           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sqrt_share_ctrl.sv
// Directed bench for sqrt_share_ctrl: one DUT with the default timeout and one
// with an 8-cycle timeout; the bench plays both the producers and the engine.
module tb_sqrt_share_ctrl;

  localparam int NR = 2;
  localparam int DW = 16;
  localparam int BW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clr   = 1'b0;
  logic busy_a;
  logic busy_t;
  int   n_cmp = 0;
  int   n_bad = 0;

  sqrt_share_ctrl_if #(.NUM_REQ(NR), .DATA_W(DW), .BUF_BIT_W(BW)) bus_a ();
  sqrt_share_ctrl_if #(.NUM_REQ(NR), .DATA_W(DW), .BUF_BIT_W(BW)) bus_t ();

  sqrt_share_ctrl #(.NUM_REQ(NR), .DATA_W(DW), .BUF_BIT_W(BW), .TIMEOUT_CYC(256)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .bus(bus_a), .busy_o(busy_a)
  );

  sqrt_share_ctrl #(.NUM_REQ(NR), .DATA_W(DW), .BUF_BIT_W(BW), .TIMEOUT_CYC(8)) dut_t (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .bus(bus_t), .busy_o(busy_t)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick();
    n_cmp++;
    if ({bus_a.req_ready_o, bus_a.res_valid_o, bus_a.sqrt_start_o, bus_a.sqrt_clr_o,
         bus_a.res_err_o, busy_a} !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 0", {bus_a.req_ready_o, bus_a.res_valid_o,
               bus_a.sqrt_start_o, bus_a.sqrt_clr_o, bus_a.res_err_o, busy_a});
    end
    n_cmp++;
    if (bus_a.sqrt_din_o !== 40'h0 || bus_a.res_data_o !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_data: din %h res %h want 0", bus_a.sqrt_din_o, bus_a.res_data_o);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bus_a.req_data_i[0] = 40'h00_0000_0090;
    bus_a.req_valid_i   = 2'b01;
    tick();  // cycle 0
    n_cmp++;
    if (bus_a.req_ready_o !== 2'b01 || busy_a !== 1'b1) begin
      n_bad++;
      $display("FAIL single_grant: ready %b busy %b want 01 1", bus_a.req_ready_o, busy_a);
    end
    tick();  // cycle 1
    n_cmp++;
    if (bus_a.sqrt_start_o !== 1'b1 || bus_a.sqrt_din_o !== 40'h90 || bus_a.req_ready_o !== 2'b00) begin
      n_bad++;
      $display("FAIL single_issue: start %b din %h ready %b want 1 90 00",
               bus_a.sqrt_start_o, bus_a.sqrt_din_o, bus_a.req_ready_o);
    end
    bus_a.req_valid_i = 2'b00;
    repeat (8) tick();  // cycle 9
    n_cmp++;
    if (bus_a.res_valid_o !== 2'b00 || bus_a.sqrt_start_o !== 1'b0 || bus_a.sqrt_din_o !== 40'h90) begin
      n_bad++;
      $display("FAIL single_wait: vld %b start %b din %h want 00 0 90",
               bus_a.res_valid_o, bus_a.sqrt_start_o, bus_a.sqrt_din_o);
    end
    tick();  // cycle 10
    bus_a.sqrt_dout_i = 16'd12;
    bus_a.sqrt_done_i = 1'b1;
    tick();  // cycle 11
    n_cmp++;
    if (bus_a.res_valid_o !== 2'b01 || bus_a.res_data_o !== 16'd12 || bus_a.res_err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL single_resp: vld %b data %0d err %b want 01 12 0",
               bus_a.res_valid_o, bus_a.res_data_o, bus_a.res_err_o);
    end
    bus_a.sqrt_done_i = 1'b0;
    bus_a.sqrt_dout_i = 16'h0;
    tick();  // cycle 12
    n_cmp++;
    if (bus_a.res_valid_o !== 2'b00 || bus_a.res_data_o !== 16'd12 || busy_a !== 1'b0 ||
        bus_a.sqrt_din_o !== 40'h0) begin
      n_bad++;
      $display("FAIL single_idle: vld %b data %0d busy %b din %h want 00 12 0 0",
               bus_a.res_valid_o, bus_a.res_data_o, busy_a, bus_a.sqrt_din_o);
    end
  endtask

  task automatic test_clr();
    bus_a.req_data_i[0] = 40'h11;
    bus_a.req_data_i[1] = 40'h22;
    bus_a.req_valid_i   = 2'b11;
    tick();
    for (int w = 0; w < 6 && bus_a.req_ready_o === 2'b00; w++) tick();
    n_cmp++;
    if (bus_a.req_ready_o !== 2'b10) begin
      n_bad++;
      $display("FAIL clr_first_grant: got %b want 10", bus_a.req_ready_o);
    end
    tick();
    n_cmp++;
    if (bus_a.sqrt_din_o !== 40'h22) begin
      n_bad++;
      $display("FAIL clr_operand: got %h want 22", bus_a.sqrt_din_o);
    end
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_cmp++;
    if (bus_a.sqrt_clr_o !== 1'b1 || busy_a !== 1'b0 || bus_a.res_valid_o !== 2'b00 ||
        bus_a.sqrt_din_o !== 40'h0) begin
      n_bad++;
      $display("FAIL clr_effect: sclr %b busy %b vld %b din %h want 1 0 00 0",
               bus_a.sqrt_clr_o, busy_a, bus_a.res_valid_o, bus_a.sqrt_din_o);
    end
    tick();
    n_cmp++;
    if (bus_a.req_ready_o !== 2'b01 || bus_a.sqrt_clr_o !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_ptr_reset: ready %b sclr %b want 01 0", bus_a.req_ready_o, bus_a.sqrt_clr_o);
    end
    tick();
    bus_a.req_valid_i = 2'b00;
    tick();
    bus_a.sqrt_dout_i = 16'h0777;
    bus_a.sqrt_done_i = 1'b1;
    tick();
    bus_a.sqrt_done_i = 1'b0;
    n_cmp++;
    if (bus_a.res_valid_o !== 2'b01 || bus_a.res_data_o !== 16'h0777) begin
      n_bad++;
      $display("FAIL clr_after_resp: vld %b data %h want 01 0777", bus_a.res_valid_o, bus_a.res_data_o);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    logic [39:0] exp_d [2];
    logic [1:0]  exp_g;
    int          g;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_d[0] = 40'hA0_0000_0001;
    exp_d[1] = 40'hB0_0000_0002;
    bus_a.req_data_i[0] = exp_d[0];
    bus_a.req_data_i[1] = exp_d[1];
    bus_a.req_valid_i   = 2'b11;
    for (int op = 0; op < 4; op++) begin
      g     = op % 2;
      exp_g = 2'b01 << g;
      tick();
      for (int w = 0; w < 8 && bus_a.req_ready_o === 2'b00; w++) tick();
      n_cmp++;
      if (bus_a.req_ready_o !== exp_g) begin
        n_bad++;
        $display("FAIL sim_grant%0d: got %b want %b", op, bus_a.req_ready_o, exp_g);
      end
      tick();
      n_cmp++;
      if (bus_a.sqrt_din_o !== exp_d[g]) begin
        n_bad++;
        $display("FAIL sim_operand%0d: got %h want %h", op, bus_a.sqrt_din_o, exp_d[g]);
      end
      exp_d[g] = exp_d[g] + 40'h10;
      bus_a.req_data_i[g] = exp_d[g];
      tick();
      bus_a.sqrt_dout_i = 16'h0100 + 16'(op);
      bus_a.sqrt_done_i = 1'b1;
      tick();
      bus_a.sqrt_done_i = 1'b0;
      n_cmp++;
      if (bus_a.res_valid_o !== exp_g || bus_a.res_data_o !== 16'h0100 + 16'(op)) begin
        n_bad++;
        $display("FAIL sim_resp%0d: vld %b data %h want %b %h", op, bus_a.res_valid_o,
                 bus_a.res_data_o, exp_g, 16'h0100 + 16'(op));
      end
    end
    bus_a.req_valid_i = 2'b00;
    tick();
  endtask

  task automatic test_drop();
    bus_a.req_data_i[0] = 40'h33;
    bus_a.req_data_i[1] = 40'h44;
    bus_a.req_valid_i   = 2'b11;
    tick();
    n_cmp++;
    if (bus_a.req_ready_o !== 2'b01) begin
      n_bad++;
      $display("FAIL drop_grant: got %b want 01", bus_a.req_ready_o);
    end
    bus_a.req_valid_i = 2'b00;
    tick();
    n_cmp++;
    if (bus_a.sqrt_start_o !== 1'b0 || busy_a !== 1'b0) begin
      n_bad++;
      $display("FAIL drop_abort: start %b busy %b want 0 0", bus_a.sqrt_start_o, busy_a);
    end
    bus_a.req_valid_i = 2'b11;
    tick();
    n_cmp++;
    if (bus_a.req_ready_o !== 2'b01) begin
      n_bad++;
      $display("FAIL drop_ptr_kept: got %b want 01", bus_a.req_ready_o);
    end
    bus_a.req_valid_i = 2'b10;
    tick();
    n_cmp++;
    if (bus_a.sqrt_start_o !== 1'b0) begin
      n_bad++;
      $display("FAIL drop_abort2: start %b want 0", bus_a.sqrt_start_o);
    end
    for (int w = 0; w < 6 && bus_a.req_ready_o === 2'b00; w++) tick();
    n_cmp++;
    if (bus_a.req_ready_o !== 2'b10) begin
      n_bad++;
      $display("FAIL drop_other: got %b want 10", bus_a.req_ready_o);
    end
    tick();
    n_cmp++;
    if (bus_a.sqrt_start_o !== 1'b1 || bus_a.sqrt_din_o !== 40'h44) begin
      n_bad++;
      $display("FAIL drop_issue: start %b din %h want 1 44", bus_a.sqrt_start_o, bus_a.sqrt_din_o);
    end
    bus_a.req_valid_i = 2'b00;
    tick();
    bus_a.sqrt_dout_i = 16'h0044;
    bus_a.sqrt_done_i = 1'b1;
    tick();
    bus_a.sqrt_done_i = 1'b0;
    n_cmp++;
    if (bus_a.res_valid_o !== 2'b10 || bus_a.res_data_o !== 16'h0044) begin
      n_bad++;
      $display("FAIL drop_resp: vld %b data %h want 10 0044", bus_a.res_valid_o, bus_a.res_data_o);
    end
    tick();
  endtask

  task automatic test_timeout();
    bus_t.req_data_i[1] = 40'h77;
    bus_t.req_valid_i   = 2'b10;
    tick();
    n_cmp++;
    if (bus_t.req_ready_o !== 2'b10) begin
      n_bad++;
      $display("FAIL to_pre_grant: got %b want 10", bus_t.req_ready_o);
    end
    tick();
    bus_t.req_valid_i = 2'b00;
    tick();
    bus_t.sqrt_dout_i = 16'h00AA;
    bus_t.sqrt_done_i = 1'b1;
    tick();
    bus_t.sqrt_done_i = 1'b0;
    n_cmp++;
    if (bus_t.res_valid_o !== 2'b10 || bus_t.res_data_o !== 16'h00AA || bus_t.res_err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL to_pre_resp: vld %b data %h err %b want 10 00aa 0",
               bus_t.res_valid_o, bus_t.res_data_o, bus_t.res_err_o);
    end
    tick();
    bus_t.req_data_i[0] = 40'h55;
    bus_t.req_valid_i   = 2'b01;
    tick();  // cycle 0
    n_cmp++;
    if (bus_t.req_ready_o !== 2'b01) begin
      n_bad++;
      $display("FAIL to_grant: got %b want 01", bus_t.req_ready_o);
    end
    tick();  // cycle 1
    bus_t.req_valid_i = 2'b00;
    n_cmp++;
    if (bus_t.sqrt_start_o !== 1'b1) begin
      n_bad++;
      $display("FAIL to_start: got %b want 1", bus_t.sqrt_start_o);
    end
    repeat (7) tick();  // cycle 8
    n_cmp++;
    if (bus_t.sqrt_clr_o !== 1'b0 || bus_t.res_valid_o !== 2'b00) begin
      n_bad++;
      $display("FAIL to_early: sclr %b vld %b want 0 00", bus_t.sqrt_clr_o, bus_t.res_valid_o);
    end
    tick();  // cycle 9
    n_cmp++;
    if (bus_t.sqrt_clr_o !== 1'b1 || bus_t.res_valid_o !== 2'b01 || bus_t.res_err_o !== 1'b1 ||
        bus_t.res_data_o !== 16'h0) begin
      n_bad++;
      $display("FAIL to_abort: sclr %b vld %b err %b data %h want 1 01 1 0",
               bus_t.sqrt_clr_o, bus_t.res_valid_o, bus_t.res_err_o, bus_t.res_data_o);
    end
    tick();  // cycle 10
    n_cmp++;
    if (bus_t.sqrt_clr_o !== 1'b0 || bus_t.res_err_o !== 1'b0 || busy_t !== 1'b0) begin
      n_bad++;
      $display("FAIL to_after: sclr %b err %b busy %b want 0 0 0", bus_t.sqrt_clr_o, bus_t.res_err_o, busy_t);
    end
    bus_t.sqrt_dout_i = 16'hBEEF;
    bus_t.sqrt_done_i = 1'b1;
    tick();
    bus_t.sqrt_done_i = 1'b0;
    n_cmp++;
    if (bus_t.res_valid_o !== 2'b00 || busy_t !== 1'b0 || bus_t.res_data_o !== 16'h0) begin
      n_bad++;
      $display("FAIL to_late_done: vld %b busy %b data %h want 00 0 0",
               bus_t.res_valid_o, busy_t, bus_t.res_data_o);
    end
  endtask

  task automatic test_rst_mid();
    bus_a.req_data_i[0] = 40'h99;
    bus_a.req_valid_i   = 2'b01;
    tick();
    tick();
    tick();
    tick();  // mid WAIT
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus_a.req_ready_o, bus_a.res_valid_o, bus_a.sqrt_start_o, bus_a.sqrt_clr_o, busy_a} !== 7'h00 ||
        bus_a.sqrt_din_o !== 40'h0) begin
      n_bad++;
      $display("FAIL rst_async: ctrl %b din %h want 0 0", {bus_a.req_ready_o, bus_a.res_valid_o,
               bus_a.sqrt_start_o, bus_a.sqrt_clr_o, busy_a}, bus_a.sqrt_din_o);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (bus_a.req_ready_o !== 2'b01) begin
      n_bad++;
      $display("FAIL rst_regrant: got %b want 01", bus_a.req_ready_o);
    end
    tick();
    bus_a.req_valid_i = 2'b00;
    n_cmp++;
    if (bus_a.sqrt_start_o !== 1'b1 || bus_a.sqrt_din_o !== 40'h99) begin
      n_bad++;
      $display("FAIL rst_reissue: start %b din %h want 1 99", bus_a.sqrt_start_o, bus_a.sqrt_din_o);
    end
    tick();
    bus_a.sqrt_dout_i = 16'h0099;
    bus_a.sqrt_done_i = 1'b1;
    tick();
    bus_a.sqrt_done_i = 1'b0;
    n_cmp++;
    if (bus_a.res_valid_o !== 2'b01 || bus_a.res_data_o !== 16'h0099) begin
      n_bad++;
      $display("FAIL rst_resp: vld %b data %h want 01 0099", bus_a.res_valid_o, bus_a.res_data_o);
    end
    tick();
  endtask

  initial begin
    bus_a.req_valid_i = '0;
    bus_a.req_data_i  = '0;
    bus_a.sqrt_dout_i = '0;
    bus_a.sqrt_done_i = 1'b0;
    bus_t.req_valid_i = '0;
    bus_t.req_data_i  = '0;
    bus_t.sqrt_dout_i = '0;
    bus_t.sqrt_done_i = 1'b0;
    test_reset();
    test_single();
    test_clr();
    test_simultaneous();
    test_drop();
    test_timeout();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
